// File: rtl/draw_pkg.sv
// Shared types and constants for the shape drawing engine.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PLOT,
    NEXT_ARC,
    DONE
  } state_t;

  typedef enum logic {
    MODE_CIRCLE,
    MODE_REULEAUX
  } mode_t;

  // sqrt(3)/6 and sqrt(3)/3 in Q8 fixed point, used for the triangle vertices.
  localparam int SQRT3_6_Q8 = 74;
  localparam int SQRT3_3_Q8 = 148;

  // Signed coordinate width wide enough that centre +/- offsets never wrap.
  function automatic int coord_width(input int xw, input int yw, input int rw);
    int m;
    m = (xw > yw) ? xw : yw;
    m = (m > rw) ? m : rw;
    return m + 4;
  endfunction

endpackage

// File: rtl/circle_octant_gen.sv
// Midpoint circle walker: emits one octant offset per step and flags the
// final point of the arc.
module circle_octant_gen #(
  parameter int RW = 8,
  parameter int CW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [RW-1:0]        r,
  output logic signed [CW-1:0] dx,
  output logic signed [CW-1:0] dy,
  output logic                 last
);

  localparam logic signed [CW-1:0] ZERO = '0;
  localparam logic signed [CW-1:0] ONE  = CW'(1);

  logic signed [CW-1:0] ox, oy, crit;
  logic signed [CW-1:0] ox_n, oy_n, crit_n;
  logic signed [CW-1:0] r_ext;
  logic [2:0]           octant;

  assign r_ext = CW'(r);

  // Walker update applied after the eighth octant point of an iteration.
  always_comb begin
    oy_n   = oy + ONE;
    ox_n   = ox;
    crit_n = crit + (oy_n <<< 1) + ONE;
    if (crit > ZERO) begin
      ox_n   = ox - ONE;
      crit_n = crit + ((oy_n - ox_n) <<< 1) + ONE;
    end
  end

  // The arc ends when the updated walker has crossed the 45-degree line.
  assign last = (octant == 3'd7) && (oy_n > ox_n);

  // Octant offset for the current point, in the fixed drawing order.
  always_comb begin
    dx = ZERO;
    dy = ZERO;
    case (octant)
      3'd0: begin dx =  ox; dy =  oy; end
      3'd1: begin dx =  oy; dy =  ox; end
      3'd2: begin dx = -oy; dy =  ox; end
      3'd3: begin dx = -ox; dy =  oy; end
      3'd4: begin dx = -ox; dy = -oy; end
      3'd5: begin dx = -oy; dy = -ox; end
      3'd6: begin dx =  oy; dy = -ox; end
      default: begin dx = ox; dy = -oy; end
    endcase
  end

  // Walker registers: load starts a new arc, step advances one point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox     <= ZERO;
      oy     <= ZERO;
      crit   <= ZERO;
      octant <= 3'd0;
    end else if (load) begin
      ox     <= r_ext;
      oy     <= ZERO;
      crit   <= ONE - r_ext;
      octant <= 3'd0;
    end else if (step) begin
      octant <= octant + 3'd1;
      if (octant == 3'd7) begin
        ox   <= ox_n;
        oy   <= oy_n;
        crit <= crit_n;
      end
    end
  end

endmodule

// File: rtl/shape_drawer.sv
// Circle / Reuleaux triangle outline drawer feeding the VGA plot port.
// Handshake: start is sampled in IDLE; done stays high in DONE until start
// drops; abort cancels any active drawing; vga_plot is a one-cycle write
// strobe per on-screen, in-arc pixel.
module shape_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int RW       = 8,
  parameter int COLW     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            mode,
  input  logic [COLW-1:0] colour,
  input  logic [XW-1:0]   centre_x,
  input  logic [YW-1:0]   centre_y,
  input  logic [RW-1:0]   size,
  output logic            done,
  output logic            busy,
  output logic [XW-1:0]   vga_x,
  output logic [YW-1:0]   vga_y,
  output logic [COLW-1:0] vga_colour,
  output logic            vga_plot
);

  import draw_pkg::*;

  localparam int CW = coord_width(XW, YW, RW);
  localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);
  localparam logic [7:0] K_H1 = 8'(SQRT3_6_Q8);
  localparam logic [7:0] K_H2 = 8'(SQRT3_3_Q8);

  state_t               state, state_n;
  mode_t                mode_q;
  logic [COLW-1:0]      colour_q;
  logic [XW-1:0]        cx_q;
  logic [YW-1:0]        cy_q;
  logic [RW-1:0]        size_q;
  logic [1:0]           arc_q;
  logic signed [CW-1:0] ac_x, ac_y, ac_x_n, ac_y_n;
  logic [RW+7:0]        prod1, prod2;
  logic signed [CW-1:0] cx_s, cy_s, half_s, h1_s, h2_s;
  logic signed [CW-1:0] c1x, c1y, c2x, c3x, c3y;
  logic signed [CW-1:0] dx, dy, px, py;
  logic                 walk_load, walk_step, walk_last;
  logic                 in_arc, on_screen;

  circle_octant_gen #(.RW(RW), .CW(CW)) u_walker (
    .clk  (clk),
    .rst  (rst),
    .load (walk_load),
    .step (walk_step),
    .r    (size_q),
    .dx   (dx),
    .dy   (dy),
    .last (walk_last)
  );

  // Triangle vertices derived from the latched centre and diameter.
  always_comb begin
    prod1  = {8'd0, size_q} * {{RW{1'b0}}, K_H1};
    prod2  = {8'd0, size_q} * {{RW{1'b0}}, K_H2};
    h1_s   = CW'(prod1 >> 8);
    h2_s   = CW'(prod2 >> 8);
    half_s = CW'(size_q >> 1);
    cx_s   = CW'(cx_q);
    cy_s   = CW'(cy_q);
    c1x    = cx_s + half_s;
    c1y    = cy_s + h1_s;
    c2x    = cx_s - half_s;
    c3x    = cx_s;
    c3y    = cy_s - h2_s;
  end

  // Arc centre for the arc about to be drawn.
  always_comb begin
    ac_x_n = cx_s;
    ac_y_n = cy_s;
    if (mode_q == MODE_REULEAUX) begin
      case (arc_q)
        2'd0:    begin ac_x_n = c3x; ac_y_n = c3y; end
        2'd1:    begin ac_x_n = c1x; ac_y_n = c1y; end
        default: begin ac_x_n = c2x; ac_y_n = c1y; end
      endcase
    end
  end

  // Candidate pixel, arc filter and screen clipping.
  always_comb begin
    px     = ac_x + dx;
    py     = ac_y + dy;
    in_arc = 1'b1;
    if (mode_q == MODE_REULEAUX) begin
      case (arc_q)
        2'd0:    in_arc = (py >= c1y);
        2'd1:    in_arc = (px <= c3x) && (py <= c1y);
        default: in_arc = (px >= c3x) && (py <= c1y);
      endcase
    end
    on_screen = !px[CW-1] && (px < SW_S) && !py[CW-1] && (py < SH_S);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Request latches, arc index and arc centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_CIRCLE;
      colour_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      size_q   <= '0;
      arc_q    <= 2'd0;
      ac_x     <= '0;
      ac_y     <= '0;
    end else begin
      if (state == IDLE && start) begin
        mode_q   <= mode_t'(mode);
        colour_q <= colour;
        cx_q     <= centre_x;
        cy_q     <= centre_y;
        size_q   <= size;
        arc_q    <= 2'd0;
      end
      if (state == SETUP) begin
        ac_x <= ac_x_n;
        ac_y <= ac_y_n;
      end
      if (state == NEXT_ARC && !abort && arc_q != 2'd2) arc_q <= arc_q + 2'd1;
    end
  end

  // Next-state and output decode; abort takes priority over every advance.
  always_comb begin
    state_n    = state;
    done       = 1'b0;
    busy       = 1'b0;
    vga_plot   = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    walk_load  = 1'b0;
    walk_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = SETUP;
      end
      SETUP: begin
        busy      = 1'b1;
        walk_load = !abort;
        state_n   = abort ? IDLE : PLOT;
      end
      PLOT: begin
        busy       = 1'b1;
        vga_x      = px[XW-1:0];
        vga_y      = py[YW-1:0];
        vga_colour = colour_q;
        vga_plot   = in_arc && on_screen && !abort;
        walk_step  = !abort;
        if (abort)          state_n = IDLE;
        else if (walk_last) state_n = (mode_q == MODE_CIRCLE) ? DONE : NEXT_ARC;
      end
      NEXT_ARC: begin
        busy = 1'b1;
        if (abort)               state_n = IDLE;
        else if (arc_q == 2'd2)  state_n = DONE;
        else                     state_n = SETUP;
      end
      DONE: begin
        done = 1'b1;
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shape_drawer.sv
// Randomised scoreboard bench for shape_drawer.
module tb_shape_drawer;

  localparam int XW = 8, YW = 7, RW = 8, COLW = 3;
  localparam int SW = 160, SH = 120;
  localparam int PW = XW + YW + COLW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, start, abort, mode;
  logic [COLW-1:0] colour;
  logic [XW-1:0] centre_x;
  logic [YW-1:0] centre_y;
  logic [RW-1:0] size;
  logic done, busy, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [COLW-1:0] vga_colour;

  always #5 clk = ~clk;

  shape_drawer #(.SCREEN_W(SW), .SCREEN_H(SH), .XW(XW), .YW(YW), .RW(RW), .COLW(COLW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .size(size),
    .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] exp_q[$];
  int busy_cnt = 0;
  int plot_cnt = 0;
  bit chk_radius = 1'b0;

  // Reference cycle list of one drawing: kind 0 = setup, 1 = plot point, 2 = arc gap.
  int cyc_kind[$];
  int cyc_x[$];
  int cyc_y[$];
  bit cyc_plot[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Geometric model: outline points of each arc with the shape's keep rules.
  task automatic build_model(input int md, input int cx, input int cy, input int sz);
    int h1, h2, half, v1x, v1y, v2x, v3x, v3y;
    int acx, acy, ox, oy, d, narcs, x, y;
    int offx[8], offy[8];
    bit keep, on;
    cyc_kind.delete(); cyc_x.delete(); cyc_y.delete(); cyc_plot.delete();
    h1 = (sz * 74) / 256;
    h2 = (sz * 148) / 256;
    half = sz / 2;
    v1x = cx + half; v1y = cy + h1;
    v2x = cx - half;
    v3x = cx;        v3y = cy - h2;
    narcs = md ? 3 : 1;
    for (int a = 0; a < narcs; a++) begin
      if (!md)        begin acx = cx;  acy = cy;  end
      else if (a == 0) begin acx = v3x; acy = v3y; end
      else if (a == 1) begin acx = v1x; acy = v1y; end
      else             begin acx = v2x; acy = v1y; end
      cyc_kind.push_back(0); cyc_x.push_back(0); cyc_y.push_back(0); cyc_plot.push_back(1'b0);
      ox = sz; oy = 0; d = 1 - sz;
      do begin
        offx = '{ox, oy, -oy, -ox, -ox, -oy, oy, ox};
        offy = '{oy, ox, ox, oy, -oy, -ox, -ox, -oy};
        for (int k = 0; k < 8; k++) begin
          x = acx + offx[k];
          y = acy + offy[k];
          if (!md)         keep = 1'b1;
          else if (a == 0) keep = (y >= v1y);
          else if (a == 1) keep = (x <= v3x) && (y <= v1y);
          else             keep = (x >= v3x) && (y <= v1y);
          on = (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
          cyc_kind.push_back(1); cyc_x.push_back(x); cyc_y.push_back(y);
          cyc_plot.push_back(keep && on);
        end
        oy = oy + 1;
        if (d <= 0) d = d + 2 * oy + 1;
        else begin
          ox = ox - 1;
          d = d + 2 * (oy - ox) + 1;
        end
      end while (oy <= ox);
      if (md) begin
        cyc_kind.push_back(2); cyc_x.push_back(0); cyc_y.push_back(0); cyc_plot.push_back(1'b0);
      end
    end
  endtask

  // Queue the expected pixels of the first 'upto' busy cycles.
  task automatic push_exp(input int upto, input int col);
    for (int i = 0; i < upto; i++)
      if (cyc_plot[i]) exp_q.push_back({8'(cyc_x[i]), 7'(cyc_y[i]), 3'(col)});
  endtask

  // Busy-cycle index of the n-th entry of a given kind (-1 if absent).
  function automatic int nth_kind(input int kind, input int n);
    int c;
    c = 0;
    for (int i = 0; i < cyc_kind.size(); i++)
      if (cyc_kind[i] == kind) begin
        if (c == n) return i;
        c++;
      end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [PW-1:0] e;
    int rdx, rdy, rerr;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (vga_plot) begin
        plot_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_plot: got (%0d,%0d) col %0d, expected no plot", vga_x, vga_y, vga_colour);
        end else begin
          e = exp_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) begin
            n_bad++;
            $display("FAIL pixel: got (%0d,%0d) col %0d, expected (%0d,%0d) col %0d",
                     vga_x, vga_y, vga_colour, e[PW-1 -: XW], e[COLW +: YW], e[COLW-1:0]);
          end
        end
        if (chk_radius) begin
          rdx = int'(vga_x) - 80;
          rdy = int'(vga_y) - 60;
          rerr = rdx * rdx + rdy * rdy - 1600;
          chk("radius_error_within_80", int'(rerr <= 80 && rerr >= -80), 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic draw(input int md, input int cx, input int cy, input int sz, input int col,
                      input bit chk_lat, output int busy_seen, output int plots_seen);
    int b0, p0, lat;
    bit ok;
    build_model(md, cx, cy, sz);
    push_exp(cyc_kind.size(), col);
    @(posedge clk); #1;
    mode = md[0]; centre_x = XW'(cx); centre_y = YW'(cy); size = RW'(sz); colour = COLW'(col);
    start = 1'b1;
    b0 = busy_cnt; p0 = plot_cnt;
    lat = -1;
    if (chk_lat) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (vga_plot) begin lat = i; break; end
      end
      chk("first_plot_latency", lat, 2);
    end
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("done_reached", int'(ok), 1);
    busy_seen = busy_cnt - b0;
    plots_seen = plot_cnt - p0;
    chk("busy_cycles", busy_seen, cyc_kind.size());
    chk("plots_outstanding", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("done_held_with_start", int'(done), 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_until_idle", int'(done), 1);
    @(negedge clk);
    chk("done_cleared", int'(done), 0);
    chk("busy_in_idle", int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic abort_at(input int md, input int cx, input int cy, input int sz, input int col,
                          input int busy_idx, input string tag);
    bit done_seen;
    build_model(md, cx, cy, sz);
    push_exp(busy_idx, col);
    @(posedge clk); #1;
    mode = md[0]; centre_x = XW'(cx); centre_y = YW'(cy); size = RW'(sz); colour = COLW'(col);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (busy_idx) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_plot"}, int'(vga_plot), 0);
    done_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk({tag, "_no_done"}, int'(done_seen), 0);
    chk({tag, "_plots_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_plot"}, int'(vga_plot), 0);
    chk({tag, "_x"}, int'(vga_x), 0);
    chk({tag, "_y"}, int'(vga_y), 0);
    chk({tag, "_colour"}, int'(vga_colour), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bs, ps, b_mid, b_edge, ridx;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    colour = '0; centre_x = '0; centre_y = '0; size = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Degenerate circle: eight cycles at the centre.
    draw(0, 80, 60, 0, 5, 1'b1, bs, ps);
    chk("size0_plots", ps, 8);
    chk("size0_busy", bs, 9);

    // Radius 1 in the corner: negative coordinates are clipped.
    draw(0, 0, 0, 1, 2, 1'b0, bs, ps);
    chk("size1_plots", ps, 6);
    chk("size1_busy", bs, 17);

    // Radius 40 circle, every pixel near the ideal circle.
    chk_radius = 1'b1;
    draw(0, 80, 60, 40, 3, 1'b1, bs, ps);
    chk_radius = 1'b0;

    // Reuleaux triangle, diameter 40.
    draw(1, 80, 60, 40, 6, 1'b0, bs, ps);

    // Clipping near the bottom-right corner does not change the timing.
    draw(0, 80, 60, 50, 1, 1'b0, b_mid, ps);
    draw(0, 150, 115, 50, 1, 1'b0, b_edge, ps);
    chk("clip_same_cycles", b_edge, b_mid);

    // Aborts in SETUP, after 100 plot cycles, and in an arc gap.
    abort_at(0, 80, 60, 30, 4, 0, "abort_setup");
    build_model(1, 80, 60, 40);
    abort_at(1, 80, 60, 40, 7, nth_kind(1, 100), "abort_plot100");
    build_model(1, 70, 50, 20);
    abort_at(1, 70, 50, 20, 2, nth_kind(2, 0), "abort_next_arc");

    // Reset in the middle of a Reuleaux drawing.
    ridx = 60;
    build_model(1, 80, 60, 40);
    push_exp(ridx, 6);
    @(posedge clk); #1;
    mode = 1'b1; centre_x = 8'd80; centre_y = 7'd60; size = 8'd40; colour = 3'd6;
    start = 1'b1;
    repeat (ridx + 1) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    start = 1'b0;
    chk("mid_reset_plots_outstanding", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    draw(1, 90, 64, 36, 5, 1'b0, bs, ps);

    // Random shapes, including off-screen centres.
    for (int n = 0; n < 8; n++)
      draw(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 60)), int'($urandom_range(0, 7)), 1'b0, bs, ps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
